// File: rtl/if_id_connection_test_if.sv
// Signal bundle between the IF/ID integration block and its surroundings:
// write-back and EXE/MEM status in, decoded ID-stage control and operands out.
interface if_id_connection_test_if #(
    parameter int REG_FILE_ADDR_LEN = 4,
    parameter int REG_FILE_SIZE     = 32,
    parameter int EXE_CMD_LEN       = 4
);
    logic                         forward_EN;
    logic                         writeEn;
    logic [REG_FILE_ADDR_LEN-1:0] dest;
    logic [REG_FILE_SIZE-1:0]     writeVal;
    logic [REG_FILE_ADDR_LEN-1:0] dest_EXE;
    logic [REG_FILE_ADDR_LEN-1:0] dest_MEM;
    logic                         WB_EN_EXE;
    logic                         WB_EN_MEM;
    logic                         MEM_R_EN_EXE;
    logic                         flagZ;

    logic                         is_imm;
    logic                         ST;
    logic                         hazard_detected;
    logic                         brTaken;
    logic                         MEM_R_EN;
    logic                         MEM_W_EN;
    logic                         WB_EN;
    logic [EXE_CMD_LEN-1:0]       EXE_CMD;
    logic [3:0]                   branch_comm;
    logic [REG_FILE_ADDR_LEN-1:0] src1;
    logic [REG_FILE_ADDR_LEN-1:0] src2;
    logic [REG_FILE_SIZE-1:0]     val1;
    logic [REG_FILE_SIZE-1:0]     val2;

    modport slave (
        input  forward_EN, writeEn, dest, writeVal, dest_EXE, dest_MEM,
               WB_EN_EXE, WB_EN_MEM, MEM_R_EN_EXE, flagZ,
        output is_imm, ST, hazard_detected, brTaken, MEM_R_EN, MEM_W_EN, WB_EN,
               EXE_CMD, branch_comm, src1, src2, val1, val2
    );

    modport master (
        output forward_EN, writeEn, dest, writeVal, dest_EXE, dest_MEM,
               WB_EN_EXE, WB_EN_MEM, MEM_R_EN_EXE, flagZ,
        input  is_imm, ST, hazard_detected, brTaken, MEM_R_EN, MEM_W_EN, WB_EN,
               EXE_CMD, branch_comm, src1, src2, val1, val2
    );
endinterface

// File: rtl/if_id_connection_test.sv
// Front of the 5-stage pipeline: PC + instruction ROM, IF/ID register, and the
// ID stage (decode, register file, hazard detection, branch resolution).
module if_id_connection_test #(
    parameter int    REG_FILE_ADDR_LEN = 4,
    parameter int    REG_FILE_SIZE     = 32,
    parameter int    EXE_CMD_LEN       = 4,
    parameter int    IMEM_DEPTH        = 256,
    parameter string IMEM_FILE         = "instr.hex"
) (
    input logic                    clk,
    input logic                    rst,
    if_id_connection_test_if.slave bus
);
    // PC arithmetic wraps in PC_W bits, so IMEM_DEPTH is expected to be a power of two
    localparam int PC_W = $clog2(IMEM_DEPTH);
    localparam int NREG = 1 << REG_FILE_ADDR_LEN;

    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;
    localparam logic [3:0] OP_ST   = 4'd10;
    localparam logic [3:0] OP_BEZ  = 4'd11;
    localparam logic [3:0] OP_BNE  = 4'd12;
    localparam logic [3:0] OP_JMP  = 4'd13;

    logic [31:0]              imem [IMEM_DEPTH];
    logic [PC_W-1:0]          pc;
    logic [PC_W-1:0]          ifid_pc;
    logic [31:0]              ifid_instr;
    logic [REG_FILE_SIZE-1:0] rf [NREG];

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
    end

    logic [3:0]                   op;
    logic [REG_FILE_ADDR_LEN-1:0] rs1, rs2;
    logic [REG_FILE_SIZE-1:0]     imm_ext;
    logic                         unused_rd;

    assign op        = ifid_instr[31:28];
    assign rs1       = ifid_instr[20 +: REG_FILE_ADDR_LEN];
    assign rs2       = ifid_instr[16 +: REG_FILE_ADDR_LEN];
    assign imm_ext   = {{(REG_FILE_SIZE-16){ifid_instr[15]}}, ifid_instr[15:0]};
    assign unused_rd = ^ifid_instr[27:24];

    logic [EXE_CMD_LEN-1:0] dec_cmd;
    logic [3:0]             dec_bc;
    logic                   dec_wb, dec_imm, dec_mr, dec_mw, use1, use2;

    always_comb begin
        dec_cmd = '0;
        dec_bc  = '0;
        dec_wb  = 1'b0;
        dec_imm = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                dec_cmd = EXE_CMD_LEN'(op);
                dec_wb  = 1'b1;
                use1    = 1'b1;
                use2    = 1'b1;
            end
            OP_ADDI: begin
                dec_cmd = EXE_CMD_LEN'(1);
                dec_imm = 1'b1;
                dec_wb  = 1'b1;
                use1    = 1'b1;
            end
            OP_LD: begin
                dec_cmd = EXE_CMD_LEN'(1);
                dec_imm = 1'b1;
                dec_mr  = 1'b1;
                dec_wb  = 1'b1;
                use1    = 1'b1;
            end
            OP_ST: begin
                dec_cmd = EXE_CMD_LEN'(1);
                dec_mw  = 1'b1;
                use1    = 1'b1;
                use2    = 1'b1;
            end
            OP_BEZ: dec_bc = 4'd1;
            OP_BNE: dec_bc = 4'd2;
            OP_JMP: dec_bc = 4'd3;
            default: ;
        endcase
    end

    // Register reads bypass the same-cycle write-back so WB->ID needs no stall
    logic [REG_FILE_SIZE-1:0] rd1, rd2;

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != '0) rd1 = (bus.writeEn && bus.dest == rs1) ? bus.writeVal : rf[rs1];
        if (rs2 != '0) rd2 = (bus.writeEn && bus.dest == rs2) ? bus.writeVal : rf[rs2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (bus.writeEn && bus.dest != '0) begin
            rf[bus.dest] <= bus.writeVal;
        end
    end

    logic hit_exe, hit_mem, hazard, br_taken;
    logic [PC_W-1:0] target;

    always_comb begin
        hit_exe = bus.WB_EN_EXE && bus.dest_EXE != '0 &&
                  ((use1 && bus.dest_EXE == rs1) || (use2 && bus.dest_EXE == rs2));
        hit_mem = bus.WB_EN_MEM && bus.dest_MEM != '0 &&
                  ((use1 && bus.dest_MEM == rs1) || (use2 && bus.dest_MEM == rs2));
        hazard  = bus.forward_EN ? (bus.MEM_R_EN_EXE && hit_exe) : (hit_exe || hit_mem);
        br_taken = !hazard && ((dec_bc == 4'd1 && bus.flagZ) ||
                               (dec_bc == 4'd2 && !bus.flagZ) ||
                               (dec_bc == 4'd3));
        target  = ifid_pc + ifid_instr[PC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= '0;
            ifid_pc    <= '0;
            ifid_instr <= '0;
        end else if (hazard) begin
            pc         <= pc;
        end else if (br_taken) begin
            pc         <= target;
            ifid_pc    <= '0;
            ifid_instr <= '0;
        end else begin
            pc         <= pc + PC_W'(1);
            ifid_pc    <= pc;
            ifid_instr <= imem[pc];
        end
    end

    // Outputs are gated by rst so an asynchronous reset silences them at once,
    // including the purely combinational paths from the status inputs.
    logic live, issue;

    always_comb begin
        live                = rst;
        issue               = rst && !hazard;
        bus.hazard_detected = live && hazard;
        bus.brTaken         = live && br_taken;
        bus.WB_EN           = issue && dec_wb;
        bus.is_imm          = issue && dec_imm;
        bus.MEM_R_EN        = issue && dec_mr;
        bus.MEM_W_EN        = issue && dec_mw;
        bus.ST              = issue && dec_mw;
        bus.EXE_CMD         = issue ? dec_cmd : '0;
        bus.branch_comm     = issue ? dec_bc : 4'd0;
        bus.src1            = live ? rs1 : '0;
        bus.src2            = live ? rs2 : '0;
        bus.val1            = live ? rd1 : '0;
        bus.val2            = live ? (dec_imm ? imm_ext : rd2) : '0;
    end
endmodule

// File: tb/tb_if_id_connection_test.sv
// Bench for if_id_connection_test: directed pipeline scenarios followed by a
// randomized run against a behavioural model of the front-end.
module tb_if_id_connection_test;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_id_connection_test_if bus ();
    if_id_connection_test #(.IMEM_FILE("")) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom_m [256];
    int          m_pc, m_ifid_pc;
    logic [31:0] m_ifid;
    logic [31:0] m_rf [16];

    task automatic load_rom();
        for (int i = 0; i < 256; i++) dut.imem[i] = rom_m[i];
    endtask

    task automatic clear_inputs();
        bus.forward_EN   = 1'b0;
        bus.writeEn      = 1'b0;
        bus.dest         = '0;
        bus.writeVal     = '0;
        bus.dest_EXE     = '0;
        bus.dest_MEM     = '0;
        bus.WB_EN_EXE    = 1'b0;
        bus.WB_EN_MEM    = 1'b0;
        bus.MEM_R_EN_EXE = 1'b0;
        bus.flagZ        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [86:0] all_outs();
        return {bus.is_imm, bus.ST, bus.hazard_detected, bus.brTaken, bus.MEM_R_EN,
                bus.MEM_W_EN, bus.WB_EN, bus.EXE_CMD, bus.branch_comm, bus.src1,
                bus.src2, bus.val1, bus.val2};
    endfunction

    task automatic test_reset();
        clear_inputs();
        bus.writeEn = 1'b1; bus.dest = 4'd1; bus.writeVal = 32'h1234_5678;
        #20;
        n_checks++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outs: got %0h want 0", all_outs()); end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.WB_EN !== 1'b0) begin n_fail++; $display("FAIL reset_nop_wb: got %0h want 0", bus.WB_EN); end
        n_checks++; if (bus.src1 !== 4'd0) begin n_fail++; $display("FAIL reset_nop_src1: got %0h want 0", bus.src1); end
    endtask

    task automatic test_decode();
        bus.forward_EN = 1'b1;
        step();
        n_checks++; if (bus.WB_EN !== 1'b1) begin n_fail++; $display("FAIL addi_wb: got %0h want 1", bus.WB_EN); end
        n_checks++; if (bus.is_imm !== 1'b1) begin n_fail++; $display("FAIL addi_imm: got %0h want 1", bus.is_imm); end
        n_checks++; if (bus.src1 !== 4'd0) begin n_fail++; $display("FAIL addi_src1: got %0h want 0", bus.src1); end
        n_checks++; if (bus.val2 !== 32'd5) begin n_fail++; $display("FAIL addi_val2: got %0h want 5", bus.val2); end
        n_checks++; if (bus.EXE_CMD !== 4'd1) begin n_fail++; $display("FAIL addi_cmd: got %0h want 1", bus.EXE_CMD); end
        step();
        n_checks++; if (bus.src1 !== 4'd1 || bus.src2 !== 4'd1) begin n_fail++; $display("FAIL add_src: got %0h/%0h want 1/1", bus.src1, bus.src2); end
        n_checks++; if (bus.is_imm !== 1'b0) begin n_fail++; $display("FAIL add_imm: got %0h want 0", bus.is_imm); end
        n_checks++; if (bus.EXE_CMD !== 4'd1 || bus.WB_EN !== 1'b1) begin n_fail++; $display("FAIL add_ctrl: got cmd %0h wb %0h want 1/1", bus.EXE_CMD, bus.WB_EN); end
    endtask

    task automatic test_bypass();
        bus.writeEn = 1'b1; bus.dest = 4'd0; bus.writeVal = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (bus.val1 !== 32'd0) begin n_fail++; $display("FAIL r0_write_ignored: got %0h want 0", bus.val1); end
        bus.dest = 4'd1; bus.writeVal = 32'd7;
        #1;
        n_checks++; if (bus.val1 !== 32'd7 || bus.val2 !== 32'd7) begin n_fail++; $display("FAIL bypass: got %0h/%0h want 7/7", bus.val1, bus.val2); end
    endtask

    task automatic test_load_use();
        bus.forward_EN = 1'b1; bus.MEM_R_EN_EXE = 1'b1; bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 4'd1;
        #1;
        n_checks++; if (bus.hazard_detected !== 1'b1) begin n_fail++; $display("FAIL lu_hazard: got %0h want 1", bus.hazard_detected); end
        n_checks++; if (bus.WB_EN !== 1'b0 || bus.EXE_CMD !== 4'd0) begin n_fail++; $display("FAIL lu_bubble: got wb %0h cmd %0h want 0/0", bus.WB_EN, bus.EXE_CMD); end
        n_checks++; if (bus.src1 !== 4'd1) begin n_fail++; $display("FAIL lu_src_driven: got %0h want 1", bus.src1); end
        step();
        bus.writeEn = 1'b0;
        #1;
        n_checks++; if (bus.val1 !== 32'd7) begin n_fail++; $display("FAIL rf_stored: got %0h want 7", bus.val1); end
        step();
        n_checks++; if (bus.hazard_detected !== 1'b1 || bus.src2 !== 4'd1) begin n_fail++; $display("FAIL lu_hold: got haz %0h src2 %0h want 1/1", bus.hazard_detected, bus.src2); end
    endtask

    task automatic test_no_forward();
        bus.MEM_R_EN_EXE = 1'b0; bus.WB_EN_EXE = 1'b0; bus.forward_EN = 1'b0;
        bus.WB_EN_MEM = 1'b1; bus.dest_MEM = 4'd1;
        #1;
        n_checks++; if (bus.hazard_detected !== 1'b1) begin n_fail++; $display("FAIL nofwd_mem_hazard: got %0h want 1", bus.hazard_detected); end
        bus.forward_EN = 1'b1;
        #1;
        n_checks++; if (bus.hazard_detected !== 1'b0 || bus.WB_EN !== 1'b1) begin n_fail++; $display("FAIL fwd_no_hazard: got haz %0h wb %0h want 0/1", bus.hazard_detected, bus.WB_EN); end
        bus.WB_EN_MEM = 1'b0; bus.dest_MEM = 4'd0;
    endtask

    task automatic test_branch();
        step();
        bus.flagZ = 1'b1; bus.writeEn = 1'b1; bus.dest = 4'd0; bus.writeVal = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (bus.brTaken !== 1'b1 || bus.branch_comm !== 4'd1) begin n_fail++; $display("FAIL bez_taken: got br %0h bc %0h want 1/1", bus.brTaken, bus.branch_comm); end
        n_checks++; if (bus.val1 !== 32'd0) begin n_fail++; $display("FAIL r0_reads_zero: got %0h want 0", bus.val1); end
        step();
        bus.writeEn = 1'b0; bus.flagZ = 1'b0;
        #1;
        n_checks++; if (all_outs() !== '0) begin n_fail++; $display("FAIL flush_nop: got %0h want 0", all_outs()); end
        step();
        n_checks++; if (bus.EXE_CMD !== 4'd2 || bus.src1 !== 4'd1 || bus.src2 !== 4'd2) begin n_fail++; $display("FAIL target_pc5: got cmd %0h src %0h/%0h want 2/1/2", bus.EXE_CMD, bus.src1, bus.src2); end
        n_checks++; if (bus.val1 !== 32'd7) begin n_fail++; $display("FAIL target_val1: got %0h want 7", bus.val1); end
        step();
        #1;
        n_checks++; if (bus.brTaken !== 1'b0 || bus.branch_comm !== 4'd1) begin n_fail++; $display("FAIL bez_not_taken: got br %0h bc %0h want 0/1", bus.brTaken, bus.branch_comm); end
        step();
        n_checks++; if (bus.EXE_CMD !== 4'd4) begin n_fail++; $display("FAIL seq_fetch: got %0h want 4", bus.EXE_CMD); end
    endtask

    task automatic test_async_reset();
        bus.forward_EN = 1'b1; bus.MEM_R_EN_EXE = 1'b1; bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 4'd1;
        #1;
        n_checks++; if (bus.hazard_detected !== 1'b1 || bus.val1 !== 32'd7) begin n_fail++; $display("FAIL pre_reset: got haz %0h val1 %0h want 1/7", bus.hazard_detected, bus.val1); end
        rst = 1'b0;
        #1;
        n_checks++; if (all_outs() !== '0) begin n_fail++; $display("FAIL async_reset_outs: got %0h want 0", all_outs()); end
        clear_inputs();
        bus.forward_EN = 1'b1;
        rst = 1'b1;
        step();
        n_checks++; if (bus.is_imm !== 1'b1 || bus.val2 !== 32'd5 || bus.src1 !== 4'd0) begin n_fail++; $display("FAIL restart_pc0: got imm %0h val2 %0h src1 %0h want 1/5/0", bus.is_imm, bus.val2, bus.src1); end
        step();
        n_checks++; if (bus.src1 !== 4'd1 || bus.val1 !== 32'd0) begin n_fail++; $display("FAIL rf_cleared: got src1 %0h val1 %0h want 1/0", bus.src1, bus.val1); end
    endtask

    task automatic test_random();
        int op, rs1, rs2, imm, bc;
        bit alu, immop, ld, st, u1, u2, e_hit, m_hit, haz, taken;
        logic [31:0] v1, v2;
        logic [18:0] exp_ctrl, got_ctrl;
        for (int i = 0; i < 256; i++) begin
            int mag;
            logic [15:0] im16;
            mag  = $urandom_range(0, 12);
            im16 = ($urandom_range(0, 1) == 1) ? 16'(-mag) : 16'(mag);
            rom_m[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), im16};
        end
        load_rom();
        clear_inputs();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        m_pc = 0; m_ifid_pc = 0; m_ifid = '0;
        for (int r = 0; r < 16; r++) m_rf[r] = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.forward_EN   = 1'($urandom_range(0, 1));
            bus.writeEn      = 1'($urandom_range(0, 1));
            bus.dest         = 4'($urandom_range(0, 3));
            bus.writeVal     = $urandom;
            bus.dest_EXE     = 4'($urandom_range(0, 3));
            bus.dest_MEM     = 4'($urandom_range(0, 3));
            bus.WB_EN_EXE    = ($urandom_range(0, 2) == 0);
            bus.WB_EN_MEM    = ($urandom_range(0, 2) == 0);
            bus.MEM_R_EN_EXE = 1'($urandom_range(0, 1));
            bus.flagZ        = 1'($urandom_range(0, 1));
            #1;
            op  = int'(m_ifid[31:28]);
            rs1 = int'(m_ifid[23:20]);
            rs2 = int'(m_ifid[19:16]);
            imm = int'($signed(m_ifid[15:0]));
            alu   = (op >= 1 && op <= 7);
            immop = (op == 8 || op == 9);
            ld    = (op == 9);
            st    = (op == 10);
            u1    = (op >= 1 && op <= 10);
            u2    = alu || st;
            e_hit = bus.WB_EN_EXE && bus.dest_EXE != 0 &&
                    ((u1 && int'(bus.dest_EXE) == rs1) || (u2 && int'(bus.dest_EXE) == rs2));
            m_hit = bus.WB_EN_MEM && bus.dest_MEM != 0 &&
                    ((u1 && int'(bus.dest_MEM) == rs1) || (u2 && int'(bus.dest_MEM) == rs2));
            haz   = bus.forward_EN ? (bus.MEM_R_EN_EXE && e_hit) : (e_hit || m_hit);
            bc    = (op >= 11 && op <= 13) ? op - 10 : 0;
            taken = !haz && (bc == 3 || (bc == 1 && bus.flagZ) || (bc == 2 && !bus.flagZ));
            v1 = (rs1 == 0) ? 32'd0 : (bus.writeEn && int'(bus.dest) == rs1) ? bus.writeVal : m_rf[rs1];
            v2 = immop ? 32'(imm) :
                 (rs2 == 0) ? 32'd0 : (bus.writeEn && int'(bus.dest) == rs2) ? bus.writeVal : m_rf[rs2];
            exp_ctrl = {haz, taken,
                        !haz && (alu || immop), !haz && immop, !haz && ld, !haz && st, !haz && st,
                        haz ? 4'd0 : alu ? 4'(op) : (op >= 8 && op <= 10) ? 4'd1 : 4'd0,
                        haz ? 4'd0 : 4'(bc), 4'd0};
            got_ctrl = {bus.hazard_detected, bus.brTaken, bus.WB_EN, bus.is_imm, bus.MEM_R_EN,
                        bus.MEM_W_EN, bus.ST, bus.EXE_CMD, bus.branch_comm, 4'd0};
            n_checks++; if (got_ctrl !== exp_ctrl) begin n_fail++; $display("FAIL rnd_ctrl cyc %0d: got %0h want %0h", cyc, got_ctrl, exp_ctrl); end
            n_checks++; if (bus.src1 !== 4'(rs1) || bus.src2 !== 4'(rs2)) begin n_fail++; $display("FAIL rnd_src cyc %0d: got %0h/%0h want %0h/%0h", cyc, bus.src1, bus.src2, rs1, rs2); end
            n_checks++; if (bus.val1 !== v1) begin n_fail++; $display("FAIL rnd_val1 cyc %0d: got %0h want %0h", cyc, bus.val1, v1); end
            n_checks++; if (bus.val2 !== v2) begin n_fail++; $display("FAIL rnd_val2 cyc %0d: got %0h want %0h", cyc, bus.val2, v2); end
            if (bus.writeEn && bus.dest != 0) m_rf[bus.dest] = bus.writeVal;
            if (!haz) begin
                if (taken) begin
                    m_pc      = (((m_ifid_pc + imm) % 256) + 256) % 256;
                    m_ifid    = '0;
                    m_ifid_pc = 0;
                end else begin
                    m_ifid    = rom_m[m_pc];
                    m_ifid_pc = m_pc;
                    m_pc      = (m_pc + 1) % 256;
                end
            end
            step();
        end
    endtask

    initial begin
        clear_inputs();
        #1;
        for (int i = 0; i < 256; i++) rom_m[i] = '0;
        rom_m[0] = 32'h8100_0005;
        rom_m[1] = 32'h1211_0000;
        rom_m[2] = 32'hB000_0003;
        rom_m[3] = 32'h5321_0000;
        rom_m[4] = 32'h6321_0000;
        rom_m[5] = 32'h2412_0000;
        rom_m[6] = 32'hB000_0003;
        rom_m[7] = 32'h4511_0000;
        load_rom();
        test_reset();
        test_decode();
        test_bypass();
        test_load_use();
        test_no_forward();
        test_branch();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
